// File: rtl/id_issue_stage_pkg.sv
// Package for the decode/issue stage: MIPS opcode/funct codes, ALU op and
// result-select encodings, and small helpers shared by decoder and stage.
package id_issue_stage_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_PREF    = 6'b110011;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_SYNC = 6'b001111;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  typedef enum logic [7:0] {
    ALU_NOP = 8'h00,
    ALU_SRL = 8'h02,
    ALU_SRA = 8'h03,
    ALU_AND = 8'h24,
    ALU_OR  = 8'h25,
    ALU_XOR = 8'h26,
    ALU_NOR = 8'h27,
    ALU_SLL = 8'h7C
  } alu_op_e;

  // SEL_NOP doubles as the "no execute result" select for nops and illegals
  typedef enum logic [2:0] {
    SEL_NOP   = 3'b000,
    SEL_LOGIC = 3'b001,
    SEL_SHIFT = 3'b010
  } alu_sel_e;

  localparam logic [31:0] ZERO_WORD    = '0;
  localparam logic [4:0]  NOP_REG_ADDR = '0;

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/id_issue_stage_decode.sv
// id_decode: pure combinational instruction decoder.
// Ports:
//   inst     in   instruction word
//   alu_op   out  ALU operation code
//   alu_sel  out  result select
//   re1/re2  out  source read enables (rs / rt); 0 means use imm1 / imm2
//   ra1/ra2  out  source addresses inst[25:21] / inst[20:16]
//   waddr    out  destination register, we: destination write enable
//   imm1     out  immediate used for source 1 when re1=0 (shift amount)
//   imm2     out  immediate used for source 2 when re2=0 (imm16 / lui)
//   swap     out  variable shift: src1 takes rt value, src2 takes rs[4:0]
//   illegal  out  opcode/funct not in the supported set
module id_decode
  import id_issue_stage_pkg::*;
(
  input  logic [31:0] inst,
  output logic [7:0]  alu_op,
  output logic [2:0]  alu_sel,
  output logic        re1,
  output logic        re2,
  output logic [4:0]  ra1,
  output logic [4:0]  ra2,
  output logic [4:0]  waddr,
  output logic        we,
  output logic [31:0] imm1,
  output logic [31:0] imm2,
  output logic        swap,
  output logic        illegal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [15:0] imm16;

  assign opcode = inst[31:26];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign sa     = inst[10:6];
  assign funct  = inst[5:0];
  assign imm16  = inst[15:0];

  assign ra1 = rs;
  assign ra2 = rt;

  always_comb begin
    alu_op  = ALU_NOP;
    alu_sel = SEL_NOP;
    re1     = 1'b0;
    re2     = 1'b0;
    waddr   = NOP_REG_ADDR;
    we      = 1'b0;
    imm1    = ZERO_WORD;
    imm2    = ZERO_WORD;
    swap    = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            if (sa == 5'd0) begin
              re1     = 1'b1;
              re2     = 1'b1;
              waddr   = rd;
              we      = 1'b1;
              alu_sel = SEL_LOGIC;
              case (funct)
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_XOR:  alu_op = ALU_XOR;
                default: alu_op = ALU_NOR;
              endcase
            end else begin
              illegal = 1'b1;
            end
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            if (rs == 5'd0) begin
              re2     = 1'b1;
              imm1    = {27'd0, sa};
              waddr   = rd;
              we      = 1'b1;
              alu_sel = SEL_SHIFT;
              case (funct)
                FN_SLL:  alu_op = ALU_SLL;
                FN_SRL:  alu_op = ALU_SRL;
                default: alu_op = ALU_SRA;
              endcase
            end else begin
              illegal = 1'b1;
            end
          end
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            if (sa == 5'd0) begin
              re1     = 1'b1;
              re2     = 1'b1;
              swap    = 1'b1;
              waddr   = rd;
              we      = 1'b1;
              alu_sel = SEL_SHIFT;
              case (funct)
                FN_SLLV: alu_op = ALU_SLL;
                FN_SRLV: alu_op = ALU_SRL;
                default: alu_op = ALU_SRA;
              endcase
            end else begin
              illegal = 1'b1;
            end
          end
          FN_SYNC: begin
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        re1     = 1'b1;
        imm2    = zext16(imm16);
        waddr   = rt;
        we      = 1'b1;
        alu_sel = SEL_LOGIC;
        case (opcode)
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: alu_op = ALU_XOR;
        endcase
      end
      OP_LUI: begin
        // lui executes as $0 | {imm16,16'h0}
        imm2    = {imm16, 16'h0000};
        waddr   = rt;
        we      = 1'b1;
        alu_sel = SEL_LOGIC;
        alu_op  = ALU_OR;
      end
      OP_PREF: begin
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_issue_stage.sv
// id_issue_stage: decode/issue stage between the IF/ID register and EX.
// Decodes logic/shift instructions (id_decode), resolves operands through
// FWD_PORTS forwarding sources (port 0 youngest), interlocks on load-use,
// and registers the bundle into ID/EX with a valid/ready handshake.
// Ports:
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready/in_pc/in_inst       upstream handshake + instruction
//   rf_re*/rf_ra*/rf_rd*                  register file read port pair
//   fwd_we/fwd_pending/fwd_addr/fwd_data  packed forwarding sources
//   out_valid/out_ready + out_* fields    registered ID/EX bundle
// Option: define ID_STALL_CNT_EN to add stall_cnt[31:0], a saturating count
//   of cycles with a valid instruction held back by a hazard.
module id_issue_stage
  import id_issue_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RADDR_W   = 5,
  parameter int FWD_PORTS = 2,
  parameter int ALU_OP_W  = 8,
  parameter int ALU_SEL_W = 3
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_pc,
  input  logic [31:0]                   in_inst,
  output logic                          rf_re1,
  output logic                          rf_re2,
  output logic [RADDR_W-1:0]            rf_ra1,
  output logic [RADDR_W-1:0]            rf_ra2,
  input  logic [DATA_W-1:0]             rf_rd1,
  input  logic [DATA_W-1:0]             rf_rd2,
  input  logic [FWD_PORTS-1:0]          fwd_we,
  input  logic [FWD_PORTS-1:0]          fwd_pending,
  input  logic [FWD_PORTS*RADDR_W-1:0]  fwd_addr,
  input  logic [FWD_PORTS*DATA_W-1:0]   fwd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_pc,
  output logic [ALU_OP_W-1:0]           out_alu_op,
  output logic [ALU_SEL_W-1:0]          out_alu_sel,
  output logic [DATA_W-1:0]             out_src1,
  output logic [DATA_W-1:0]             out_src2,
  output logic [RADDR_W-1:0]            out_waddr,
  output logic                          out_we,
  output logic                          out_illegal
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]                   stall_cnt
`endif
);

  logic [7:0]          dec_alu_op;
  logic [2:0]          dec_alu_sel;
  logic                dec_re1;
  logic                dec_re2;
  logic [4:0]          dec_ra1;
  logic [4:0]          dec_ra2;
  logic [4:0]          dec_waddr;
  logic                dec_we;
  logic [31:0]         dec_imm1;
  logic [31:0]         dec_imm2;
  logic                dec_swap;
  logic                dec_illegal;

  logic                hit_a;
  logic                hit_b;
  logic                pend_a;
  logic                pend_b;
  logic [DATA_W-1:0]   fwd_a;
  logic [DATA_W-1:0]   fwd_b;
  logic [DATA_W-1:0]   opnd_a;
  logic [DATA_W-1:0]   opnd_b;
  logic [DATA_W-1:0]   src1_d;
  logic [DATA_W-1:0]   src2_d;
  logic                hazard;
  logic                xfer;

  id_decode u_decode (
    .inst    (in_inst),
    .alu_op  (dec_alu_op),
    .alu_sel (dec_alu_sel),
    .re1     (dec_re1),
    .re2     (dec_re2),
    .ra1     (dec_ra1),
    .ra2     (dec_ra2),
    .waddr   (dec_waddr),
    .we      (dec_we),
    .imm1    (dec_imm1),
    .imm2    (dec_imm2),
    .swap    (dec_swap),
    .illegal (dec_illegal)
  );

  assign rf_re1 = dec_re1;
  assign rf_re2 = dec_re2;
  assign rf_ra1 = RADDR_W'(dec_ra1);
  assign rf_ra2 = RADDR_W'(dec_ra2);

  // First (youngest) matching writer wins; its pending flag decides the stall.
  always_comb begin
    hit_a  = 1'b0;
    hit_b  = 1'b0;
    pend_a = 1'b0;
    pend_b = 1'b0;
    fwd_a  = '0;
    fwd_b  = '0;
    for (int unsigned i = 0; i < FWD_PORTS; i++) begin
      if (!hit_a && fwd_we[i] && (fwd_addr[i*RADDR_W +: RADDR_W] == rf_ra1)) begin
        hit_a  = 1'b1;
        pend_a = fwd_pending[i];
        fwd_a  = fwd_data[i*DATA_W +: DATA_W];
      end
      if (!hit_b && fwd_we[i] && (fwd_addr[i*RADDR_W +: RADDR_W] == rf_ra2)) begin
        hit_b  = 1'b1;
        pend_b = fwd_pending[i];
        fwd_b  = fwd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    if (!dec_re1)            opnd_a = DATA_W'(dec_imm1);
    else if (rf_ra1 == '0)   opnd_a = '0;
    else if (hit_a)          opnd_a = fwd_a;
    else                     opnd_a = rf_rd1;

    if (!dec_re2)            opnd_b = DATA_W'(dec_imm2);
    else if (rf_ra2 == '0)   opnd_b = '0;
    else if (hit_b)          opnd_b = fwd_b;
    else                     opnd_b = rf_rd2;
  end

  assign hazard = (dec_re1 && (rf_ra1 != '0) && hit_a && pend_a) ||
                  (dec_re2 && (rf_ra2 != '0) && hit_b && pend_b);

  // Variable shifts take the value from rt and the amount from rs[4:0].
  assign src1_d = dec_swap ? opnd_b : opnd_a;
  assign src2_d = dec_swap ? {{(DATA_W-5){1'b0}}, opnd_a[4:0]} : opnd_b;

  // Flush opens the input so the upstream beat is consumed and discarded.
  assign in_ready = !rst && (flush || (!hazard && (!out_valid || out_ready)));
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_alu_op  <= '0;
      out_alu_sel <= '0;
      out_src1    <= '0;
      out_src2    <= '0;
      out_waddr   <= '0;
      out_we      <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_alu_op  <= ALU_OP_W'(dec_alu_op);
      out_alu_sel <= ALU_SEL_W'(dec_alu_sel);
      out_src1    <= src1_d;
      out_src2    <= src2_d;
      out_waddr   <= RADDR_W'(dec_waddr);
      out_we      <= dec_we;
      out_illegal <= dec_illegal;
    end else if (out_ready || !out_valid) begin
      // Bundle consumed (or none) with nothing new: bubble, fields hold.
      out_valid <= 1'b0;
    end
  end

`ifdef ID_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_issue_stage.sv
module tb_id_issue_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        rf_re1, rf_re2;
  logic [4:0]  rf_ra1, rf_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic [1:0]  fwd_we, fwd_pending;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [7:0]  out_alu_op;
  logic [2:0]  out_alu_sel;
  logic [31:0] out_src1, out_src2;
  logic [4:0]  out_waddr;
  logic        out_we;
  logic        out_illegal;
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  id_issue_stage #(
    .DATA_W(32), .RADDR_W(5), .FWD_PORTS(2), .ALU_OP_W(8), .ALU_SEL_W(3)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .rf_re1(rf_re1), .rf_re2(rf_re2), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .fwd_we(fwd_we), .fwd_pending(fwd_pending), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_op(out_alu_op), .out_alu_sel(out_alu_sel),
    .out_src1(out_src1), .out_src2(out_src2),
    .out_waddr(out_waddr), .out_we(out_we), .out_illegal(out_illegal)
`ifdef ID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [1:0] we, input logic [1:0] pend,
                       input logic [9:0] addr, input logic [63:0] data);
    in_inst = inst; rf_rd1 = rd1; rf_rd2 = rd2;
    fwd_we = we; fwd_pending = pend; fwd_addr = addr; fwd_data = data;
  endtask

  // ---------------- reference model ----------------
  // Expected ALU codes: and 24, or 25, xor 26, nor 27, sll 7C, srl 02, sra 03.
  logic [7:0]  e_op;
  logic [2:0]  e_sel;
  logic [31:0] e_s1, e_s2;
  logic [4:0]  e_waddr;
  logic        e_we, e_ill, e_use_rs, e_use_rt, e_hz;

  function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'd0;
    for (int p = 0; p < 2; p++)
      if (fwd_we[p] && fwd_addr[p*5 +: 5] == r) return fwd_data[p*32 +: 32];
    return rf;
  endfunction

  function automatic bit reg_waits(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    for (int p = 0; p < 2; p++)
      if (fwd_we[p] && fwd_addr[p*5 +: 5] == r) return fwd_pending[p];
    return 1'b0;
  endfunction

  task automatic ref_eval();
    logic [5:0]  opc, fn;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic [31:0] a, b;
    opc = in_inst[31:26]; rs = in_inst[25:21]; rt = in_inst[20:16];
    rd = in_inst[15:11]; sa = in_inst[10:6]; fn = in_inst[5:0]; imm = in_inst[15:0];
    a = reg_value(rs, rf_rd1);
    b = reg_value(rt, rf_rd2);
    e_op = 8'h00; e_sel = 3'd0; e_s1 = 32'd0; e_s2 = 32'd0; e_waddr = 5'd0;
    e_we = 1'b0; e_ill = 1'b0; e_use_rs = 1'b0; e_use_rt = 1'b0;
    if (opc == 6'h00) begin
      if (fn inside {6'h24, 6'h25, 6'h26, 6'h27}) begin
        if (sa != 0) e_ill = 1'b1;
        else begin
          e_use_rs = 1; e_use_rt = 1; e_s1 = a; e_s2 = b; e_waddr = rd; e_we = 1; e_sel = 3'd1;
          e_op = (fn == 6'h24) ? 8'h24 : (fn == 6'h25) ? 8'h25 : (fn == 6'h26) ? 8'h26 : 8'h27;
        end
      end else if (fn inside {6'h00, 6'h02, 6'h03}) begin
        if (rs != 0) e_ill = 1'b1;
        else begin
          e_use_rt = 1; e_s1 = 32'(sa); e_s2 = b; e_waddr = rd; e_we = 1; e_sel = 3'd2;
          e_op = (fn == 6'h00) ? 8'h7C : (fn == 6'h02) ? 8'h02 : 8'h03;
        end
      end else if (fn inside {6'h04, 6'h06, 6'h07}) begin
        if (sa != 0) e_ill = 1'b1;
        else begin
          e_use_rs = 1; e_use_rt = 1; e_s1 = b; e_s2 = a % 32; e_waddr = rd; e_we = 1; e_sel = 3'd2;
          e_op = (fn == 6'h04) ? 8'h7C : (fn == 6'h06) ? 8'h02 : 8'h03;
        end
      end else if (fn != 6'h0F) begin
        e_ill = 1'b1;
      end
    end else if (opc inside {6'h0C, 6'h0D, 6'h0E}) begin
      e_use_rs = 1; e_s1 = a; e_s2 = 32'(imm); e_waddr = rt; e_we = 1; e_sel = 3'd1;
      e_op = (opc == 6'h0C) ? 8'h24 : (opc == 6'h0D) ? 8'h25 : 8'h26;
    end else if (opc == 6'h0F) begin
      e_s2 = imm * 32'h10000; e_waddr = rt; e_we = 1; e_sel = 3'd1; e_op = 8'h25;
    end else if (opc != 6'h33) begin
      e_ill = 1'b1;
    end
    e_hz = (e_use_rs && reg_waits(rs)) || (e_use_rt && reg_waits(rt));
  endtask

  function automatic logic [31:0] gen_inst();
    logic [4:0]  rs, rt, rd, sa, sh;
    logic [5:0]  f;
    logic [15:0] imm;
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 7));
    sa  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
    sh  = 5'($urandom);
    imm = 16'($urandom);
    case ($urandom_range(0, 11))
      0, 1, 2: return {6'h00, rs, rt, rd, sa, 6'h24 + 6'($urandom_range(0, 3))};
      3: begin
        f = ($urandom_range(0, 2) == 0) ? 6'h00 : ($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03;
        return {6'h00, ($urandom_range(0, 5) == 0) ? rs : 5'd0, rt, rd, sh, f};
      end
      4: begin
        f = ($urandom_range(0, 2) == 0) ? 6'h04 : ($urandom_range(0, 1) == 0) ? 6'h06 : 6'h07;
        return {6'h00, rs, rt, rd, sa, f};
      end
      5, 6:    return {6'h0C + 6'($urandom_range(0, 2)), rs, rt, imm};
      7:       return {6'h0F, rs, rt, imm};
      8:       return {6'h00, 20'($urandom), 6'h0F};
      9:       return {6'h33, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  // model of the registered bundle
  logic        m_valid;
  logic [31:0] m_pc, m_s1, m_s2, m_stall;
  logic [7:0]  m_op;
  logic [2:0]  m_sel;
  logic [4:0]  m_waddr;
  logic        m_we, m_ill;

  localparam logic [31:0] I_OR   = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25};
  localparam logic [31:0] I_ORI  = {6'h0D, 5'd1, 5'd5, 16'h8001};
  localparam logic [31:0] I_SLL  = {6'h00, 5'd0, 5'd2, 5'd4, 5'd3, 6'h00};
  localparam logic [31:0] I_SRL0 = {6'h00, 5'd0, 5'd0, 5'd4, 5'd1, 6'h02};
  localparam logic [31:0] I_AND  = {6'h00, 5'd7, 5'd8, 5'd6, 5'd0, 6'h24};

  initial begin
    logic exp_ready, xfer, need_new;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = 32'h0;
    drive(32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 10'h0, 64'h0);

    // ---- directed ----
    tick(); tick();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_src1", out_src1, 0);
    check_eq("rst_alu_op", out_alu_op, 0);
`ifdef ID_STALL_CNT_EN
    check_eq("rst_stall_cnt", stall_cnt, 0);
`endif
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h100;
    drive(I_OR, 32'h0F0F, 32'h00FF, 2'b00, 2'b00, 10'h0, 64'h0);
    tick();
    check_eq("or_valid", out_valid, 1);
    check_eq("or_op", out_alu_op, 8'h25);
    check_eq("or_src1", out_src1, 32'h0F0F);
    check_eq("or_src2", out_src2, 32'h00FF);
    check_eq("or_waddr", out_waddr, 3);
    check_eq("or_we", out_we, 1);
    check_eq("or_pc", out_pc, 32'h100);

    drive(I_ORI, 32'h1234, 32'h0, 2'b11, 2'b00, {5'd1, 5'd1}, {32'h1, 32'hAAAA0000});
    tick();
    check_eq("ori_src1", out_src1, 32'hAAAA0000);
    check_eq("ori_src2", out_src2, 32'h8001);
    check_eq("ori_waddr", out_waddr, 5);

    drive(I_SLL, 32'h0, 32'h1234, 2'b00, 2'b00, 10'h0, 64'h0);
    tick();
    check_eq("sll_src1", out_src1, 3);
    check_eq("sll_src2", out_src2, 32'h1234);
    check_eq("sll_sel", out_alu_sel, 3'd2);
    check_eq("sll_op", out_alu_op, 8'h7C);

    drive(I_SRL0, 32'h0, 32'h5555, 2'b01, 2'b00, {5'd0, 5'd0}, {32'h0, 32'hDEAD});
    tick();
    check_eq("srl_r0_src2", out_src2, 0);
    check_eq("srl_r0_src1", out_src1, 1);

    drive(32'hFC00_0000, 32'h0, 32'h0, 2'b00, 2'b00, 10'h0, 64'h0);
    tick();
    check_eq("ill_flag", out_illegal, 1);
    check_eq("ill_we", out_we, 0);

    // load-use interlock
    rst = 1'b1; tick(); rst = 1'b0;
    drive(I_ORI, 32'h0, 32'h0, 2'b00, 2'b00, 10'h0, 64'h0);
    tick();
    check_eq("pre_hz_valid", out_valid, 1);
    drive(I_AND, 32'h0, 32'h77, 2'b01, 2'b01, {5'd0, 5'd7}, {32'h0, 32'h55});
    #1 check_eq("hz_in_ready", in_ready, 0);
    tick();
    check_eq("hz_bubble", out_valid, 0);
    fwd_pending = 2'b00;
    #1 check_eq("hz_clear_ready", in_ready, 1);
    tick();
    check_eq("hz_issue_valid", out_valid, 1);
    check_eq("hz_issue_src1", out_src1, 32'h55);
    check_eq("hz_issue_src2", out_src2, 32'h77);
    check_eq("hz_issue_op", out_alu_op, 8'h24);
`ifdef ID_STALL_CNT_EN
    check_eq("hz_stall_cnt", stall_cnt, 1);
`endif

    // backpressure then flush
    out_ready = 1'b0;
    drive(I_OR, 32'h1111, 32'h2222, 2'b00, 2'b00, 10'h0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      #1 check_eq("bp_in_ready", in_ready, 0);
      tick();
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_src1", out_src1, 32'h55);
    end
    flush = 1'b1;
    #1 check_eq("flush_in_ready", in_ready, 1);
    tick();
    check_eq("flush_valid", out_valid, 0);
    flush = 1'b0;

    // reset during a hazard
    out_ready = 1'b1;
    drive(I_AND, 32'h0, 32'h77, 2'b01, 2'b01, {5'd0, 5'd7}, {32'h0, 32'h55});
    tick();
    check_eq("hz2_valid", out_valid, 0);
`ifdef ID_STALL_CNT_EN
    check_eq("hz2_stall_cnt", stall_cnt, 2);
`endif
    rst = 1'b1;
    #1 check_eq("rst_hz_ready", in_ready, 0);
    tick();
    check_eq("rst_hz_valid", out_valid, 0);
`ifdef ID_STALL_CNT_EN
    check_eq("rst_hz_stall", stall_cnt, 0);
`endif

    // ---- randomized against the model ----
    tick();
    m_valid = 0; m_pc = 0; m_s1 = 0; m_s2 = 0; m_op = 0; m_sel = 0;
    m_waddr = 0; m_we = 0; m_ill = 0; m_stall = 0;
    need_new = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst       = ($urandom_range(0, 59) == 0);
      flush     = !rst && ($urandom_range(0, 11) == 0);
      in_valid  = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if (need_new) begin
        in_inst  = gen_inst();
        in_pc    = in_pc + 32'd4;
        need_new = 1'b0;
      end
      rf_rd1      = $urandom;
      rf_rd2      = $urandom;
      fwd_we      = 2'($urandom);
      fwd_pending = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
      fwd_addr    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fwd_data    = {$urandom, $urandom};
      #1;
      ref_eval();
      exp_ready = !rst && (flush || (!e_hz && (!m_valid || out_ready)));
      xfer      = in_valid && exp_ready;
      check_eq("r_in_ready", in_ready, exp_ready);
      check_eq("r_re1", rf_re1, e_use_rs);
      check_eq("r_re2", rf_re2, e_use_rt);
      check_eq("r_ra1", rf_ra1, in_inst[25:21]);
      check_eq("r_ra2", rf_ra2, in_inst[20:16]);

      if (rst) begin
        m_valid = 0; m_pc = 0; m_s1 = 0; m_s2 = 0; m_op = 0; m_sel = 0;
        m_waddr = 0; m_we = 0; m_ill = 0;
      end else if (flush) begin
        m_valid = 0;
      end else if (xfer) begin
        m_valid = 1; m_pc = in_pc; m_op = e_op; m_sel = e_sel; m_s1 = e_s1; m_s2 = e_s2;
        m_waddr = e_waddr; m_we = e_we; m_ill = e_ill;
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (rst) m_stall = 0;
      else if (in_valid && e_hz && !flush && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (xfer || rst) need_new = 1'b1;

      tick();
      check_eq("r_valid", out_valid, m_valid);
      check_eq("r_pc", out_pc, m_pc);
      check_eq("r_op", out_alu_op, m_op);
      check_eq("r_sel", out_alu_sel, m_sel);
      check_eq("r_src1", out_src1, m_s1);
      check_eq("r_src2", out_src2, m_s2);
      check_eq("r_waddr", out_waddr, m_waddr);
      check_eq("r_we", out_we, m_we);
      check_eq("r_illegal", out_illegal, m_ill);
`ifdef ID_STALL_CNT_EN
      check_eq("r_stall_cnt", stall_cnt, m_stall);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
